// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one bit per cycle).
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_converter #(
  parameter int bcd_N = 16,
  parameter int bin_N = 14
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [bcd_N-1:0] BCD_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [bin_N-1:0] binary_o,
  output logic             err_o
);

  localparam int DIGITS = bcd_N / 4;
  localparam int CNT_W  = (bin_N > 1) ? $clog2(bin_N) : 1;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t             state_q, state_d;
  logic [bcd_N-1:0]   bcd_q, bcd_d;
  logic [bin_N-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [bin_N-1:0]   binary_q, binary_d;

  logic [bcd_N+bin_N-1:0] shift_v;
  logic [bcd_N-1:0]       bcd_adj;
  logic [bin_N-1:0]       bin_shift;
  logic                   digit_bad;

  // One iteration: shift the combined register right, then correct each digit that is >= 8.
  always_comb begin
    shift_v   = {bcd_q, bin_q} >> 1;
    bin_shift = shift_v[bin_N-1:0];
    bcd_adj   = shift_v[bcd_N+bin_N-1 -: bcd_N];
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd8) begin
        bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (BCD_i[4*k +: 4] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    count_d  = count_q;
    binary_d = binary_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          bcd_d   = BCD_i;
          bin_d   = '0;
          count_d = CNT_W'(bin_N - 1);
          state_d = OP;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          if (digit_bad) begin
            binary_d = '0;
            err_d    = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end
      OP: begin
        bcd_d   = bcd_adj;
        bin_d   = bin_shift;
        count_d = count_q - 1'b1;
        // The result is published on the final iteration so it is valid alongside done_o.
        if (count_q == '0) begin
          binary_d = bin_shift;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d    = 1'b0;
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      count_q  <= '0;
      binary_q <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      count_q  <= count_d;
      binary_q <= binary_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign binary_o = binary_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
  logic unused_digit_bad;
  assign unused_digit_bad = digit_bad;
`endif

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Table-driven bench for bcd_to_binary_converter plus hand-written handshake/reset sequences.
module tb_bcd_to_binary_converter;

  localparam int BIN_N = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcdIn;
  logic        readyOut;
  logic        doneOut;
  logic [13:0] binaryOut;
  logic        errOut;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  bcd_to_binary_converter #(.bcd_N(16), .bin_N(BIN_N)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .BCD_i   (bcdIn),
    .ready_o (readyOut),
    .done_o  (doneOut),
    .binary_o(binaryOut),
    .err_o   (errOut)
  );

  typedef struct {
    logic [15:0] bcd;
    int unsigned expBin;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!readyOut && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!readyOut) checkOutput("ready_timeout", 0, 1);
  endtask

  // Drives a start in an IDLE cycle; returns one tick after the accepting edge.
  task automatic applyStimulus(input logic [15:0] bcd);
    waitReady();
    bcdIn = bcd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency is counted in cycles, the cycle right after the accepting edge being 1.
  task automatic waitDone(output int unsigned lat);
    lat = 1;
    while (!doneOut && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!doneOut) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    int unsigned lat;
    int pulses;
    int edges;

    vecs[0] = '{16'h0000, 0};
    vecs[1] = '{16'h9999, 9999};
    vecs[2] = '{16'h1234, 1234};
    vecs[3] = '{16'h0001, 1};
    vecs[4] = '{16'h1000, 1000};
    vecs[5] = '{16'h8888, 8888};
    vecs[6] = '{16'h0090, 90};
    vecs[7] = '{16'h5678, 5678};
    vecs[8] = '{16'h0042, 42};
    vecs[9] = '{16'h0999, 999};

    reset = 1'b1;
    start = 1'b0;
    bcdIn = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_ready", readyOut, 1);
    checkOutput("reset_done", doneOut, 0);
    checkOutput("reset_binary", binaryOut, 0);
    checkOutput("reset_err", errOut, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].bcd);
      checkOutput($sformatf("busy_%04h", vecs[i].bcd), readyOut, 0);
      waitDone(lat);
      checkOutput($sformatf("latency_%04h", vecs[i].bcd), lat, BIN_N + 1);
      checkOutput($sformatf("binary_%04h", vecs[i].bcd), binaryOut, vecs[i].expBin);
      checkOutput($sformatf("err_%04h", vecs[i].bcd), errOut, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("ready_after_%04h", vecs[i].bcd), readyOut, 1);
      checkOutput($sformatf("done_single_%04h", vecs[i].bcd), doneOut, 0);
    end

    // start held high and operand disturbed while the conversion runs
    waitReady();
    bcdIn = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!doneOut && lat < 40) begin
      if (lat == 5) bcdIn = 16'h9999;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checkOutput("held_start_latency", lat, BIN_N + 1);
    checkOutput("held_start_binary", binaryOut, 1234);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (doneOut) pulses++;
    end
    checkOutput("held_start_extra_done", pulses, 0);
    checkOutput("held_start_idle", readyOut, 1);

    // reset in the middle of OP aborts the conversion
    applyStimulus(16'h5678);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_ready", readyOut, 1);
    checkOutput("abort_binary", binaryOut, 0);
    checkOutput("abort_done", doneOut, 0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (doneOut) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);

    // back-to-back: second start on the first ready cycle
    applyStimulus(16'h0042);
    waitDone(lat);
    edges = int'(lat) - 1;
    checkOutput("b2b_first", binaryOut, 42);
    @(posedge clk); #1;
    edges++;
    checkOutput("b2b_ready", readyOut, 1);
    bcdIn = 16'h0999;
    start = 1'b1;
    @(posedge clk); #1;
    edges++;
    start = 1'b0;
    checkOutput("b2b_accepted", readyOut, 0);
    checkOutput("b2b_period", edges, BIN_N + 2);
    waitDone(lat);
    checkOutput("b2b_second_latency", lat, BIN_N + 1);
    checkOutput("b2b_second", binaryOut, 999);

    // invalid digit operand
    applyStimulus(16'h12A4);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    checkOutput("bad_digit_done", doneOut, 1);
    checkOutput("bad_digit_err", errOut, 1);
    checkOutput("bad_digit_binary", binaryOut, 0);
    applyStimulus(16'h0007);
    waitDone(lat);
    checkOutput("after_bad_err", errOut, 0);
    checkOutput("after_bad_binary", binaryOut, 7);
`else
    pulses = 0;
    lat = 1;
    while (!doneOut && lat < 40) begin
      if (errOut) pulses++;
      @(posedge clk); #1;
      lat++;
    end
    if (errOut) pulses++;
    checkOutput("bad_digit_latency", lat, BIN_N + 1);
    checkOutput("bad_digit_err_zero", pulses, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
